// File: rtl/instr_queue_if.sv
// Rename-to-issue handshake bundle for instr_queue: enqueue side, writeback wakeup
// broadcasts and the issue side. wb2_* exists only when IQ_WB2_WAKEUP_EN is defined.
interface instr_queue_if #(
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned PAYLOAD_W = 96,
  parameter int unsigned CNT_W     = 5
);
  logic                 enq_valid;
  logic                 enq_ready;
  logic                 enq_uses_rs;
  logic [PREG_W-1:0]    enq_rs_phys;
  logic                 enq_rs_busy;
  logic                 enq_uses_rt;
  logic [PREG_W-1:0]    enq_rt_phys;
  logic                 enq_rt_busy;
  logic                 enq_uses_rw;
  logic [PREG_W-1:0]    enq_rw_phys;
  logic [PAYLOAD_W-1:0] enq_payload;

  logic                 wb_valid;
  logic [PREG_W-1:0]    wb_phys;
`ifdef IQ_WB2_WAKEUP_EN
  logic                 wb2_valid;
  logic [PREG_W-1:0]    wb2_phys;
`endif

  logic                 iss_valid;
  logic                 iss_ready;
  logic [PREG_W-1:0]    iss_rs_phys;
  logic [PREG_W-1:0]    iss_rt_phys;
  logic                 iss_uses_rw;
  logic [PREG_W-1:0]    iss_rw_phys;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic [CNT_W-1:0]     count;

  modport slave (
    input  enq_valid, enq_uses_rs, enq_rs_phys, enq_rs_busy,
           enq_uses_rt, enq_rt_phys, enq_rt_busy,
           enq_uses_rw, enq_rw_phys, enq_payload,
           wb_valid, wb_phys,
`ifdef IQ_WB2_WAKEUP_EN
           wb2_valid, wb2_phys,
`endif
           iss_ready,
    output enq_ready, iss_valid, iss_rs_phys, iss_rt_phys,
           iss_uses_rw, iss_rw_phys, iss_payload, count
  );

  modport master (
    output enq_valid, enq_uses_rs, enq_rs_phys, enq_rs_busy,
           enq_uses_rt, enq_rt_phys, enq_rt_busy,
           enq_uses_rw, enq_rw_phys, enq_payload,
           wb_valid, wb_phys,
`ifdef IQ_WB2_WAKEUP_EN
           wb2_valid, wb2_phys,
`endif
           iss_ready,
    input  enq_ready, iss_valid, iss_rs_phys, iss_rt_phys,
           iss_uses_rw, iss_rw_phys, iss_payload, count
  );
endinterface

// File: rtl/instr_queue.sv
// Compacting issue queue after rename: tag wakeup, oldest-ready select, wholesale flush.
// Optional second writeback wakeup port enabled by IQ_WB2_WAKEUP_EN.
module instr_queue #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned PAYLOAD_W = 96,
  parameter int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  instr_queue_if.slave q
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]     valid_q, urs_q, rs_rdy_q, urt_q, rt_rdy_q, urw_q;
  logic [PREG_W-1:0]    rs_q [DEPTH];
  logic [PREG_W-1:0]    rt_q [DEPTH];
  logic [PREG_W-1:0]    rw_q [DEPTH];
  logic [PAYLOAD_W-1:0] pl_q [DEPTH];
  logic [CNT_W-1:0]     count_q;

  logic [DEPTH-1:0]     valid_d, urs_d, rs_rdy_d, urt_d, rt_rdy_d, urw_d;
  logic [PREG_W-1:0]    rs_d [DEPTH];
  logic [PREG_W-1:0]    rt_d [DEPTH];
  logic [PREG_W-1:0]    rw_d [DEPTH];
  logic [PAYLOAD_W-1:0] pl_d [DEPTH];
  logic [CNT_W-1:0]     count_d;

  logic [DEPTH-1:0]     rs_rdy_w, rt_rdy_w, elig;
  logic [IDX_W-1:0]     sel_idx;
  logic                 iss_any, iss_fire, enq_ready, enq_fire;
  logic [CNT_W-1:0]     tail;
  logic                 enq_rs_rdy, enq_rt_rdy;

  logic                 wb2_v;
  logic [PREG_W-1:0]    wb2_p;
`ifdef IQ_WB2_WAKEUP_EN
  assign wb2_v = q.wb2_valid;
  assign wb2_p = q.wb2_phys;
`else
  assign wb2_v = 1'b0;
  assign wb2_p = '0;
`endif

  function automatic logic tag_hit(input logic [PREG_W-1:0] tag,
                                   input logic v1, input logic [PREG_W-1:0] p1,
                                   input logic v2, input logic [PREG_W-1:0] p2);
    return (v1 && (p1 == tag)) || (v2 && (p2 == tag));
  endfunction

  assign enq_ready = (count_q < CNT_W'(DEPTH));
  assign enq_fire  = q.enq_valid && enq_ready;
  assign iss_fire  = iss_any && q.iss_ready;
  assign tail      = count_q - CNT_W'(iss_fire);

  assign enq_rs_rdy = !q.enq_uses_rs || !q.enq_rs_busy ||
                      tag_hit(q.enq_rs_phys, q.wb_valid, q.wb_phys, wb2_v, wb2_p);
  assign enq_rt_rdy = !q.enq_uses_rt || !q.enq_rt_busy ||
                      tag_hit(q.enq_rt_phys, q.wb_valid, q.wb_phys, wb2_v, wb2_p);

  // Oldest eligible entry wins; selection uses registered readiness only.
  always_comb begin
    elig    = valid_q & rs_rdy_q & rt_rdy_q;
    iss_any = 1'b0;
    sel_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!iss_any && elig[i]) begin
        iss_any = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    rs_rdy_w = rs_rdy_q;
    rt_rdy_w = rt_rdy_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && tag_hit(rs_q[i], q.wb_valid, q.wb_phys, wb2_v, wb2_p))
        rs_rdy_w[i] = 1'b1;
      if (valid_q[i] && tag_hit(rt_q[i], q.wb_valid, q.wb_phys, wb2_v, wb2_p))
        rt_rdy_w[i] = 1'b1;
    end
  end

  // Next state: hold with wakeup, then close the gap left by an issued entry,
  // then place the new instruction just past the compacted tail.
  always_comb begin
    valid_d  = valid_q;
    urs_d    = urs_q;
    rs_rdy_d = rs_rdy_w;
    urt_d    = urt_q;
    rt_rdy_d = rt_rdy_w;
    urw_d    = urw_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rw_d     = rw_q;
    pl_d     = pl_q;
    count_d  = count_q + CNT_W'(enq_fire) - CNT_W'(iss_fire);

    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      if (iss_fire && (i >= 32'(sel_idx))) begin
        valid_d[i]  = valid_q[i+1];
        urs_d[i]    = urs_q[i+1];
        rs_rdy_d[i] = rs_rdy_w[i+1];
        urt_d[i]    = urt_q[i+1];
        rt_rdy_d[i] = rt_rdy_w[i+1];
        urw_d[i]    = urw_q[i+1];
        rs_d[i]     = rs_q[i+1];
        rt_d[i]     = rt_q[i+1];
        rw_d[i]     = rw_q[i+1];
        pl_d[i]     = pl_q[i+1];
      end
    end
    if (iss_fire)
      valid_d[DEPTH-1] = 1'b0;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (enq_fire && (32'(tail) == i)) begin
        valid_d[i]  = 1'b1;
        urs_d[i]    = q.enq_uses_rs;
        rs_rdy_d[i] = enq_rs_rdy;
        urt_d[i]    = q.enq_uses_rt;
        rt_rdy_d[i] = enq_rt_rdy;
        urw_d[i]    = q.enq_uses_rw;
        rs_d[i]     = q.enq_rs_phys;
        rt_d[i]     = q.enq_rt_phys;
        rw_d[i]     = q.enq_rw_phys;
        pl_d[i]     = q.enq_payload;
      end
    end

    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      urs_q    <= '0;
      rs_rdy_q <= '0;
      urt_q    <= '0;
      rt_rdy_q <= '0;
      urw_q    <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rs_q[i] <= '0;
        rt_q[i] <= '0;
        rw_q[i] <= '0;
        pl_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      urs_q    <= urs_d;
      rs_rdy_q <= rs_rdy_d;
      urt_q    <= urt_d;
      rt_rdy_q <= rt_rdy_d;
      urw_q    <= urw_d;
      count_q  <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rs_q[i] <= rs_d[i];
        rt_q[i] <= rt_d[i];
        rw_q[i] <= rw_d[i];
        pl_q[i] <= pl_d[i];
      end
    end
  end

  assign q.enq_ready   = enq_ready;
  assign q.count       = count_q;
  assign q.iss_valid   = iss_any;
  assign q.iss_rs_phys = iss_any ? rs_q[sel_idx] : '0;
  assign q.iss_rt_phys = iss_any ? rt_q[sel_idx] : '0;
  assign q.iss_uses_rw = iss_any ? urw_q[sel_idx] : 1'b0;
  assign q.iss_rw_phys = iss_any ? rw_q[sel_idx] : '0;
  assign q.iss_payload = iss_any ? pl_q[sel_idx] : '0;

endmodule
